// File: rtl/uw_frame_tx.sv
// uw_frame_tx: transmit-side QPSK burst framer.
// A start request sends a fixed unique-word preamble and then PAYLOAD_LEN
// payload dibits. Each symbol is Gray-mapped to a signed Q1.15 I/Q pair and
// presented on a registered valid/ready symbol stream.
// Optional build macro UWTX_TEST_ROT_EN adds the test_rot input. test_rot is
// captured when a frame starts, and every symbol of that frame, including the
// UW, is pre-rotated by 0/90/180/270 degrees. This supports loopback tests of
// the receiver's rotation detection.
module uw_frame_tx #(
   parameter int                 UW_LEN      = 32,
   parameter logic [63:0]        UW_PATTERN  = 64'hE4E4_1B1B_D8D8_2727,
   parameter int                 PAYLOAD_LEN = 256,
   parameter logic signed [15:0] AMP         = 16'sd23170
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         data_in,
   input  logic               data_valid,
   output logic               data_ready,
   output logic signed [15:0] i_out,
   output logic signed [15:0] q_out,
   output logic               sym_valid,
   input  logic               sym_ready,
   output logic               busy,
   output logic               frame_done
`ifdef UWTX_TEST_ROT_EN
   ,
   input  logic [1:0]         test_rot
`endif
);

   localparam int       PL_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam logic [4:0]      UW_LAST = 5'(UW_LEN - 1);
   localparam logic [PL_W-1:0] PL_LAST = PL_W'(PAYLOAD_LEN - 1);
   localparam logic [5:0]      UW_MSB  = 6'(2 * UW_LEN - 1);

   // Illegal parameter sets are reported while the design is elaborated.
   if (UW_LEN < 1 || UW_LEN > 32) begin : g_bad_uw_len
      $error("uw_frame_tx: UW_LEN=%0d is outside 1..32", UW_LEN);
   end
   if (PAYLOAD_LEN < 1) begin : g_bad_payload_len
      $error("uw_frame_tx: PAYLOAD_LEN=%0d must be at least 1", PAYLOAD_LEN);
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_UW,
      S_PAYLOAD
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [4:0]         r_uw_cnt;
   logic [PL_W-1:0]    r_pl_cnt;
   logic signed [15:0] r_i;
   logic signed [15:0] r_q;
   logic               r_valid;

   logic               w_slot_free;
   logic               w_load;
   logic [1:0]         w_dibit;
   logic [5:0]         w_uw_bit;
   logic signed [15:0] w_map_i;
   logic signed [15:0] w_map_q;
   logic signed [15:0] w_sym_i;
   logic signed [15:0] w_sym_q;

   assign i_out     = r_i;
   assign q_out     = r_q;
   assign sym_valid = r_valid;

   // Position of the high bit of the current UW dibit, counting MSB-first.
   assign w_uw_bit = UW_MSB - {r_uw_cnt, 1'b0};

   // Next state, load strobe, handshake and status decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave it unassigned and infer a latch.
      w_state_nxt = r_state;
      w_slot_free = !r_valid || sym_ready;
      w_load      = 1'b0;
      w_dibit     = 2'b00;
      data_ready  = 1'b0;
      frame_done  = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_UW;
            end
         end
         S_UW: begin
            busy    = 1'b1;
            w_dibit = {UW_PATTERN[w_uw_bit], UW_PATTERN[w_uw_bit - 6'd1]};
            if (w_slot_free) begin
               w_load = 1'b1;
               if (r_uw_cnt == UW_LAST) begin
                  w_state_nxt = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            busy       = 1'b1;
            data_ready = w_slot_free;
            w_dibit    = data_in;
            if (w_slot_free && data_valid) begin
               w_load = 1'b1;
               if (r_pl_cnt == PL_LAST) begin
                  frame_done  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Gray mapping: a set bit selects the negative amplitude on its rail.
   always_comb begin
      w_map_i = w_dibit[1] ? -AMP : AMP;
      w_map_q = w_dibit[0] ? -AMP : AMP;
   end

`ifdef UWTX_TEST_ROT_EN
   logic [1:0] r_rot;

   // Capture the test rotation when a frame starts and hold it for that frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rot <= 2'b00;
      end else if (r_state == S_IDLE && start) begin
         r_rot <= test_rot;
      end
   end

   // Pre-rotate the mapped symbol by 0/90/180/270 degrees.
   always_comb begin
      w_sym_i = w_map_i;
      w_sym_q = w_map_q;
      case (r_rot)
         2'b01: begin
            w_sym_i = -w_map_q;
            w_sym_q = w_map_i;
         end
         2'b10: begin
            w_sym_i = -w_map_i;
            w_sym_q = -w_map_q;
         end
         2'b11: begin
            w_sym_i = w_map_q;
            w_sym_q = -w_map_i;
         end
         default: begin
            w_sym_i = w_map_i;
            w_sym_q = w_map_q;
         end
      endcase
   end
`else
   assign w_sym_i = w_map_i;
   assign w_sym_q = w_map_q;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the edge.
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Symbol counters. Both are cleared while idle, so each frame starts at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_uw_cnt <= '0;
         r_pl_cnt <= '0;
      end else begin
         case (r_state)
            S_UW: begin
               if (w_load) begin
                  r_uw_cnt <= r_uw_cnt + 5'd1;
               end
            end
            S_PAYLOAD: begin
               if (w_load) begin
                  r_pl_cnt <= r_pl_cnt + PL_W'(1);
               end
            end
            default: begin
               r_uw_cnt <= '0;
               r_pl_cnt <= '0;
            end
         endcase
      end
   end

   // Output register. It loads only when the slot is free, holds while stalled,
   // and drops valid after an accepted symbol when nothing new loads.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the sample registers are reset along with valid, so an abort
      // leaves no stale symbol on the outputs.
      if (rst) begin
         r_i     <= '0;
         r_q     <= '0;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_i     <= w_sym_i;
         r_q     <= w_sym_q;
         r_valid <= 1'b1;
      end else if (sym_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule
